commit_trace_buffer: RTL and testbench

Synthesizable retire-side monitor that sits directly downstream of the single-cycle cpu core. Each cycle it classifies the core's architectural commit signals (register write, load, store, branch/NOP, halt) into trace records. It numbers each record, counts cycles and instructions, and buffers the records in a FIFO drained over a ready/valid port. This lets the trace stream be read out by a host or UART block instead of only by simulation prints.

---
 rtl/trace_pkg.sv | 70 +++++++
 rtl/trace_fifo.sv | 53 +++++
 rtl/commit_trace_buffer.sv | 199 +++++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: record kinds, FSM states, trace record.
// TRACE_CYCLE_STAMP_EN adds a capture-time cycle stamp to every record.
package trace_pkg;

    localparam int TRACE_CNT_W = 32;

    typedef enum logic [2:0] {
        KIND_REG   = 3'd0,
        KIND_LOAD  = 3'd1,
        KIND_STORE = 3'd2,
        KIND_NOP   = 3'd3,
        KIND_HALT  = 3'd4
    } kind_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Counter fields are held at the widest supported counter width.
    typedef struct packed {
`ifdef TRACE_CYCLE_STAMP_EN
        logic [TRACE_CNT_W-1:0] cycle;
`endif
        kind_e                  kind;
        logic [TRACE_CNT_W-1:0] inum;
        logic [15:0]            pc;
        logic [3:0]             rd;
        logic [15:0]            value;
        logic [15:0]            addr;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

    function automatic trace_rec_t classify(
        input logic [15:0] pc,
        input logic        reg_write,
        input logic        mem_read,
        input logic        mem_write,
        input logic        halt,
        input logic [3:0]  write_reg,
        input logic [15:0] write_data,
        input logic [15:0] mem_addr,
        input logic [15:0] mem_data
    );
        trace_rec_t r;
        r      = '0;
        r.pc   = pc;
        r.kind = KIND_NOP;
        if (reg_write && mem_read) begin
            r.kind  = KIND_LOAD;
            r.rd    = write_reg;
            r.value = write_data;
            r.addr  = mem_addr;
        end else if (reg_write) begin
            r.kind  = KIND_REG;
            r.rd    = write_reg;
            r.value = write_data;
        end else if (halt) begin
            r.kind  = KIND_HALT;
        end else if (mem_write) begin
            r.kind  = KIND_STORE;
            r.value = mem_data;
            r.addr  = mem_addr;
        end
        return r;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// A push while full is accepted only when a pop happens in the same cycle.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        rdata    = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Retire-side monitor: classifies commits into numbered trace records and buffers them.
// Define TRACE_CYCLE_STAMP_EN to add out_cycle (cycle_count at capture). CNT_W up to 32.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int MAX_CYCLES = 100000,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      pc,
    input  logic             reg_write,
    input  logic [3:0]       write_reg,
    input  logic [15:0]      write_data,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [15:0]      mem_addr,
    input  logic [15:0]      mem_data,
    input  logic             halt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_kind,
    output logic [CNT_W-1:0] out_inum,
    output logic [15:0]      out_pc,
    output logic [3:0]       out_reg,
    output logic [15:0]      out_value,
    output logic [15:0]      out_addr,
`ifdef TRACE_CYCLE_STAMP_EN
    output logic [CNT_W-1:0] out_cycle,
`endif
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] inst_count,
    output logic             done,
    output logic             timeout,
    output logic             overflow
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] inst_q, inst_d;
    logic             timeout_q, timeout_d;
    logic             overflow_q, overflow_d;
    trace_rec_t       hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;

    trace_rec_t       rec;
    trace_rec_t       wrec;
    trace_rec_t       head;
    logic [REC_W-1:0] head_bits;
    logic             fifo_push;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             room;
    logic             is_halt;
    logic             last_cycle;

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (wrec),
        .pop   (pop),
        .rdata (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        rec      = classify(pc, reg_write, mem_read, mem_write, halt,
                            write_reg, write_data, mem_addr, mem_data);
        rec.inum = TRACE_CNT_W'(inst_q);
`ifdef TRACE_CYCLE_STAMP_EN
        rec.cycle = TRACE_CNT_W'(cycle_q);
`endif
        is_halt    = (rec.kind == KIND_HALT);
        last_cycle = (cycle_q == CNT_W'(MAX_CYCLES - 1));
        head       = trace_rec_t'(head_bits);
        pop        = out_valid & out_ready;
        room       = ~fifo_full | pop;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (is_halt || last_cycle) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !hold_vld_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        done      = (state_q == ST_DONE);
        out_valid = ~fifo_empty & ~done;
        out_kind  = '0;
        out_inum  = '0;
        out_pc    = '0;
        out_reg   = '0;
        out_value = '0;
        out_addr  = '0;
`ifdef TRACE_CYCLE_STAMP_EN
        out_cycle = '0;
`endif
        if (out_valid) begin
            out_kind  = head.kind;
            out_inum  = CNT_W'(head.inum);
            out_pc    = head.pc;
            out_reg   = head.rd;
            out_value = head.value;
            out_addr  = head.addr;
`ifdef TRACE_CYCLE_STAMP_EN
            out_cycle = CNT_W'(head.cycle);
`endif
        end
        cycle_count = cycle_q;
        inst_count  = inst_q;
        timeout     = timeout_q;
        overflow    = overflow_q;
    end

    // A halt that meets a full FIFO parks in the holding register instead of dropping.
    always_comb begin
        fifo_push  = 1'b0;
        wrec       = rec;
        cycle_d    = cycle_q;
        inst_d     = inst_q;
        timeout_d  = timeout_q;
        overflow_d = overflow_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (state_q != ST_DONE) begin
            cycle_d = cycle_q + 1'b1;
        end
        unique case (state_q)
            ST_RUN: begin
                inst_d = inst_q + 1'b1;
                if (room) begin
                    fifo_push = 1'b1;
                end else if (is_halt) begin
                    hold_d     = rec;
                    hold_vld_d = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
                if (!is_halt && last_cycle) begin
                    timeout_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (hold_vld_q && room) begin
                    fifo_push  = 1'b1;
                    wrec       = hold_q;
                    hold_vld_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_q    <= '0;
            inst_q     <= '0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            cycle_q    <= cycle_d;
            inst_q     <= inst_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer.
// Main instance uses default MAX_CYCLES; a second instance uses MAX_CYCLES=20.
module tb_commit_trace_buffer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] pc = '0;
    logic reg_write = 1'b0;
    logic [3:0] write_reg = '0;
    logic [15:0] write_data = '0;
    logic mem_read = 1'b0;
    logic mem_write = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_data = '0;
    logic halt = 1'b0;
    logic out_ready = 1'b0;
    logic rdy_t = 1'b1;

    logic out_valid;
    logic [2:0] out_kind;
    logic [CNT_W-1:0] out_inum;
    logic [15:0] out_pc;
    logic [3:0] out_reg;
    logic [15:0] out_value;
    logic [15:0] out_addr;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] inst_count;
    logic done;
    logic timeout;
    logic overflow;

    logic valid_t;
    logic [2:0] kind_t;
    logic [CNT_W-1:0] inum_t;
    logic [15:0] pc_t;
    logic [3:0] reg_t;
    logic [15:0] value_t;
    logic [15:0] addr_t;
    logic [CNT_W-1:0] cycle_t;
    logic [CNT_W-1:0] inst_t;
    logic done_t;
    logic timeout_t;
    logic overflow_t;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [CNT_W-1:0] out_cycle;
    logic [CNT_W-1:0] out_cycle_t;
`endif

    always #5 clk = ~clk;

    commit_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .reg_write(reg_write),
        .write_reg(write_reg), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_data(mem_data), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_inum(out_inum), .out_pc(out_pc),
        .out_reg(out_reg), .out_value(out_value), .out_addr(out_addr),
`ifdef TRACE_CYCLE_STAMP_EN
        .out_cycle(out_cycle),
`endif
        .cycle_count(cycle_count), .inst_count(inst_count),
        .done(done), .timeout(timeout), .overflow(overflow)
    );

    commit_trace_buffer #(.DEPTH(DEPTH), .MAX_CYCLES(20), .CNT_W(CNT_W)) dut_t (
        .clk(clk), .rst_n(rst_n), .pc(pc), .reg_write(reg_write),
        .write_reg(write_reg), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_data(mem_data), .halt(halt),
        .out_valid(valid_t), .out_ready(rdy_t),
        .out_kind(kind_t), .out_inum(inum_t), .out_pc(pc_t),
        .out_reg(reg_t), .out_value(value_t), .out_addr(addr_t),
`ifdef TRACE_CYCLE_STAMP_EN
        .out_cycle(out_cycle_t),
`endif
        .cycle_count(cycle_t), .inst_count(inst_t),
        .done(done_t), .timeout(timeout_t), .overflow(overflow_t)
    );

    typedef struct {
        logic [2:0]  kind;
        int unsigned inum;
        logic [15:0] pc;
        logic [3:0]  rd;
        logic [15:0] value;
        logic [15:0] addr;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_pass = 0;
    int unsigned tb_inum = 0;
    bit running = 1'b1;
    logic [15:0] pcn = '0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("kind", 64'(out_kind), 64'(e.kind));
                chk("inum", 64'(out_inum), 64'(e.inum));
                chk("pc", 64'(out_pc), 64'(e.pc));
                chk("reg", 64'(out_reg), 64'(e.rd));
                chk("value", 64'(out_value), 64'(e.value));
                chk("addr", 64'(out_addr), 64'(e.addr));
            end
        end
    end

    task automatic commit(input logic rw, input logic mr, input logic mw,
                          input logic h, input logic [3:0] wr,
                          input logic [15:0] wd, input logic [15:0] ma,
                          input logic [15:0] md, input logic [15:0] p);
        exp_t e;
        bit room;
        reg_write = rw; mem_read = mr; mem_write = mw; halt = h;
        write_reg = wr; write_data = wd; mem_addr = ma; mem_data = md;
        pc = p;
        if (running) begin
            if (rw && mr) e.kind = 3'd1;
            else if (rw) e.kind = 3'd0;
            else if (h) e.kind = 3'd4;
            else if (mw) e.kind = 3'd2;
            else e.kind = 3'd3;
            e.inum = tb_inum;
            tb_inum++;
            e.pc = p;
            e.rd = (e.kind <= 3'd1) ? wr : 4'd0;
            e.value = (e.kind <= 3'd1) ? wd : (e.kind == 3'd2) ? md : 16'd0;
            e.addr = (e.kind == 3'd1 || e.kind == 3'd2) ? ma : 16'd0;
            room = (sb.size() < DEPTH) || (sb.size() > 0 && out_ready);
            if (e.kind == 3'd4) begin
                sb.push_back(e);
                running = 1'b0;
            end else if (room) begin
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        pcn = pcn + 16'd2;
        commit(0, 0, 0, 0, 4'd0, 16'd0, 16'd0, 16'd0, pcn);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        commit(0, 0, 0, 0, 4'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        commit(0, 0, 0, 0, 4'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        sb.delete();
        tb_inum = 0;
        running = 1'b1;
        pcn = '0;
        rst_n = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_cycle"}, 64'(cycle_count), 64'd0);
        chk({tag, "_inst"}, 64'(inst_count), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
        chk({tag, "_tmo"}, 64'(timeout), 64'd0);
        chk({tag, "_data"}, {out_pc, out_value, out_addr, 9'd0, out_kind, out_reg}, 64'd0);
    endtask

    initial begin
        // 1: reset state and a first REG record
        do_reset();
        chk_reset("rst");
        out_ready = 1'b1;
        commit(1, 0, 0, 0, 4'd3, 16'h00AB, 16'd0, 16'd0, 16'h0002);
        chk("t1_valid", 64'(out_valid), 64'd1);

        // 2: LOAD, STORE, priority corner cases
        commit(1, 1, 0, 0, 4'd5, 16'h1234, 16'h0040, 16'd0, 16'h0004);
        commit(0, 0, 1, 0, 4'd0, 16'd0, 16'h0042, 16'h5678, 16'h0006);
        commit(0, 1, 0, 0, 4'd6, 16'h1111, 16'h0044, 16'd0, 16'h0008);
        commit(1, 0, 1, 1, 4'd7, 16'h0099, 16'h0077, 16'h2222, 16'h000A);
        nop();
        nop();
        chk("t2_inst", 64'(inst_count), 64'(tb_inum));
        chk("t2_ovf", 64'(overflow), 64'd0);

        // 3: overflow with DEPTH=8 and 10 pushes
        do_reset();
        for (int i = 0; i < 8; i++) nop();
        chk("t3_ovf_at_full", 64'(overflow), 64'd0);
        nop();
        nop();
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_inst", 64'(inst_count), 64'd10);
        chk("t3_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) nop();

        // 4: halt against a full FIFO parks and drains last
        do_reset();
        for (int i = 0; i < 8; i++) nop();
        commit(0, 0, 0, 1, 4'd0, 16'd0, 16'd0, 16'd0, 16'h0100);
        chk("t4_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 3; i++)
            commit(1, 0, 0, 0, 4'd2, 16'hBEEF, 16'd0, 16'd0, 16'h0200);
        chk("t4_inst_frozen", 64'(inst_count), 64'd9);
        chk("t4_done_early", 64'(done), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 30 && !done; i++)
            commit(1, 0, 0, 0, 4'd2, 16'hBEEF, 16'd0, 16'd0, 16'h0200);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_valid", 64'(out_valid), 64'd0);
        chk("t4_sb_left", 64'(sb.size()), 64'd0);
        chk("t4_ovf_end", 64'(overflow), 64'd0);

        // 5: timeout instance with MAX_CYCLES=20
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 19; i++) nop();
        chk("t5_tmo_early", 64'(timeout_t), 64'd0);
        chk("t5_cyc19", 64'(cycle_t), 64'd19);
        nop();
        chk("t5_tmo", 64'(timeout_t), 64'd1);
        chk("t5_cyc20", 64'(cycle_t), 64'd20);
        chk("t5_inst", 64'(inst_t), 64'd20);
        for (int i = 0; i < 10 && !done_t; i++) nop();
        chk("t5_done", 64'(done_t), 64'd1);
        chk("t5_cyc_done", 64'(cycle_t), 64'd22);
        nop();
        nop();
        nop();
        chk("t5_cyc_frozen", 64'(cycle_t), 64'd22);
        chk("t5_valid", 64'(valid_t), 64'd0);
        chk("t5_main_tmo", 64'(timeout), 64'd0);

        // 6: reset in the middle of a drain
        do_reset();
        for (int i = 0; i < 9; i++) nop();
        commit(0, 0, 0, 1, 4'd0, 16'd0, 16'd0, 16'd0, 16'h0300);
        chk("t6_ovf_pre", 64'(overflow), 64'd1);
        out_ready = 1'b1;
        commit(0, 0, 0, 0, 4'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        commit(0, 0, 0, 0, 4'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        do_reset();
        chk_reset("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
